mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset datapath.
//
// Each instruction is sequenced through IF -> ID -> EXE -> MEM -> WB. Steps
// the instruction does not need are skipped. Every datapath control is a
// combinational function of (state, code, Zero, im_rdy, dm_rdy). While rst is
// high, every control is forced to 0.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   code[31:0]        instruction held in the IR (meaningful from ID onward)
//   Zero              ALU zero flag (used by beq)
//   im_rdy, dm_rdy    instruction / data memory ready handshakes
//   PCWr, IRWr        PC and IR write enables
//   ALU_OP, WDSel, GPRSel, ExtOp, GPRWr, BSel, DMWr,
//   jsome, npc_sel, jr, jal, sb, lb   datapath controls
//   state[2:0]        current FSM state (debug)
//   ill               sticky illegal-instruction flag, cleared only by rst
//
// Optional build macro MC_PERF_EN adds two counters of width PERF_W:
//   cyc_cnt           non-reset cycles
//   ret_cnt           transitions back into IF from ID/EXE/MEM/WB
//                     (this includes exits after an illegal instruction)

module mc_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] code,
  input  logic        Zero,
  input  logic        im_rdy,
  input  logic        dm_rdy,
  output logic        PCWr,
  output logic        IRWr,
  output logic [2:0]  ALU_OP,
  output logic [1:0]  WDSel,
  output logic [1:0]  GPRSel,
  output logic [1:0]  ExtOp,
  output logic        GPRWr,
  output logic        BSel,
  output logic        DMWr,
  output logic        jsome,
  output logic        npc_sel,
  output logic        jr,
  output logic        jal,
  output logic        sb,
  output logic        lb,
  output logic [2:0]  state,
  output logic        ill
`ifdef MC_PERF_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] ret_cnt
`endif
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // One bundle for every datapath control, so the reset gate covers all of them.
  typedef struct packed {
    logic       pcwr;
    logic       irwr;
    logic [2:0] alu_op;
    logic [1:0] wdsel;
    logic [1:0] gprsel;
    logic [1:0] extop;
    logic       gprwr;
    logic       bsel;
    logic       dmwr;
    logic       jsome;
    logic       npc_sel;
    logic       jr;
    logic       jal;
    logic       sb;
    logic       lb;
  } ctrl_t;

  generate
    if (PERF_W < 1) begin : g_perf_w_chk
      $error("mc_ctrl: PERF_W must be at least 1");
    end
  endgenerate

  logic [2:0] state_q, state_d;
  logic       ill_q;
  ctrl_t      c;

  // ---------------- instruction decode ----------------
  logic [5:0] op, fn;
  logic       is_r, is_ialu, is_load, is_store, is_beq, is_j, is_jal, is_jr;
  logic       is_lb, is_sb, legal;
  logic [2:0] r_alu, i_alu;
  logic [1:0] i_ext;

  // Register fields and the immediate are consumed by the datapath, not here.
  logic unused_code;
  assign unused_code = ^code[25:6];

  assign op = code[31:26];
  assign fn = code[5:0];

  always_comb begin
    is_r     = 1'b0;
    is_ialu  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_beq   = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    is_lb    = 1'b0;
    is_sb    = 1'b0;
    r_alu    = 3'b000;
    i_alu    = 3'b000;
    i_ext    = 2'b00;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADDU: begin is_r = 1'b1; r_alu = 3'b000; end
          FN_SUBU: begin is_r = 1'b1; r_alu = 3'b001; end
          FN_SLT:  begin is_r = 1'b1; r_alu = 3'b101; end
          FN_JR:   is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_J:     is_j   = 1'b1;
      OP_JAL:   is_jal = 1'b1;
      OP_BEQ:   is_beq = 1'b1;
      OP_ADDI:  begin is_ialu = 1'b1; i_alu = 3'b110; i_ext = 2'b01; end
      OP_ADDIU: begin is_ialu = 1'b1; i_alu = 3'b000; i_ext = 2'b01; end
      OP_ORI:   begin is_ialu = 1'b1; i_alu = 3'b011; i_ext = 2'b00; end
      OP_LUI:   begin is_ialu = 1'b1; i_alu = 3'b011; i_ext = 2'b10; end
      OP_LB:    begin is_load  = 1'b1; is_lb = 1'b1; end
      OP_LW:    is_load  = 1'b1;
      OP_SB:    begin is_store = 1'b1; is_sb = 1'b1; end
      OP_SW:    is_store = 1'b1;
      default:  ;
    endcase
  end

  assign legal = is_r | is_ialu | is_load | is_store | is_beq | is_j | is_jal | is_jr;

  // ---------------- controls and next state ----------------
  always_comb begin
    c       = '0;
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        // Fetch: PC <- PC+4 and IR load happen together when the word arrives.
        c.irwr  = im_rdy;
        c.pcwr  = im_rdy;
        state_d = im_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        // Only jumps finish here; everything else waits for EXE. Illegal
        // words return to fetch with no write enable raised.
        if (is_j) begin
          c.pcwr  = 1'b1;
          c.jsome = 1'b1;
        end else if (is_jal) begin
          c.pcwr   = 1'b1;
          c.jsome  = 1'b1;
          c.jal    = 1'b1;
          c.gprwr  = 1'b1;
          c.gprsel = 2'b10;
          c.wdsel  = 2'b10;
        end else if (is_jr) begin
          c.pcwr   = 1'b1;
          c.jr     = 1'b1;
          c.alu_op = 3'b011;
        end
        state_d = (legal && !(is_j || is_jal || is_jr)) ? S_EXE : S_IF;
      end
      S_EXE: begin
        if (is_r) begin
          c.alu_op = r_alu;
          state_d  = S_WB;
        end else if (is_ialu) begin
          c.alu_op = i_alu;
          c.extop  = i_ext;
          c.bsel   = 1'b1;
          state_d  = S_WB;
        end else if (is_load || is_store) begin
          c.alu_op = 3'b000;
          c.extop  = 2'b01;
          c.bsel   = 1'b1;
          state_d  = S_MEM;
        end else if (is_beq) begin
          c.alu_op  = 3'b001;
          c.npc_sel = 1'b1;
          c.pcwr    = Zero;
        end
      end
      S_MEM: begin
        // Address path stays as in EXE so the DM sees a stable address while
        // it stalls; DMWr is held for every stall cycle.
        c.alu_op = 3'b000;
        c.extop  = 2'b01;
        c.bsel   = 1'b1;
        c.dmwr   = is_store;
        c.sb     = is_sb;
        c.lb     = is_lb;
        if (!(is_load || is_store)) state_d = S_IF;
        else if (!dm_rdy)           state_d = S_MEM;
        else                        state_d = is_load ? S_WB : S_IF;
      end
      S_WB: begin
        c.gprwr  = is_r | is_ialu | is_load;
        c.gprsel = is_r ? 2'b01 : 2'b00;
        c.wdsel  = is_load ? 2'b01 : 2'b00;
        c.lb     = is_lb;
      end
      default: ;  // unused codes fall back to fetch
    endcase
    if (rst) c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID && !legal) ill_q <= 1'b1;
    end
  end

`ifdef MC_PERF_EN
  logic [PERF_W-1:0] cyc_q, ret_q;
  logic              retire;

  // An instruction ends whenever an active step hands control back to fetch.
  assign retire = (state_d == S_IF) &&
                  (state_q == S_ID || state_q == S_EXE ||
                   state_q == S_MEM || state_q == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (retire) ret_q <= ret_q + 1'b1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

  assign PCWr    = c.pcwr;
  assign IRWr    = c.irwr;
  assign ALU_OP  = c.alu_op;
  assign WDSel   = c.wdsel;
  assign GPRSel  = c.gprsel;
  assign ExtOp   = c.extop;
  assign GPRWr   = c.gprwr;
  assign BSel    = c.bsel;
  assign DMWr    = c.dmwr;
  assign jsome   = c.jsome;
  assign npc_sel = c.npc_sel;
  assign jr      = c.jr;
  assign jal     = c.jal;
  assign sb      = c.sb;
  assign lb      = c.lb;
  assign state   = state_q;
  assign ill     = ill_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl. For each instruction it builds the expected
// cycle-by-cycle trace (inputs and outputs) from the instruction's class and
// the chosen stall counts. It then replays that trace against the DUT and
// compares every output on every cycle.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] code = '0;
  logic        Zero = 1'b0, im_rdy = 1'b0, dm_rdy = 1'b0;
  logic        PCWr, IRWr, GPRWr, BSel, DMWr, jsome, npc_sel, jr, jal, sb, lb, ill;
  logic [2:0]  ALU_OP, state;
  logic [1:0]  WDSel, GPRSel, ExtOp;
`ifdef MC_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mc_ctrl #(.PERF_W(32)) dut (
    .clk(clk), .rst(rst), .code(code), .Zero(Zero), .im_rdy(im_rdy), .dm_rdy(dm_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .ALU_OP(ALU_OP), .WDSel(WDSel), .GPRSel(GPRSel),
    .ExtOp(ExtOp), .GPRWr(GPRWr), .BSel(BSel), .DMWr(DMWr), .jsome(jsome),
    .npc_sel(npc_sel), .jr(jr), .jal(jal), .sb(sb), .lb(lb), .state(state), .ill(ill)
`ifdef MC_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4, K_ADDI = 5,
                 K_ADDIU = 6, K_LUI = 7, K_LW = 8, K_SW = 9, K_LB = 10, K_SB = 11,
                 K_BEQ = 12, K_J = 13, K_JAL = 14, K_ILL = 15;

  typedef struct {
    logic [2:0] st;
    logic       pcwr, irwr;
    logic [2:0] alu;
    logic [1:0] wd, gs, ext;
    logic       gprwr, bsel, dmwr, jsome, npc, jr, jal, sb, lb, ill;
    logic       z, imr, dmr;
  } cyc_t;

  cyc_t        plan[$];
  logic [23:0] obs[$];
  logic        ill_m = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [23:0] pk(cyc_t c);
    return {c.st, c.pcwr, c.irwr, c.alu, c.wd, c.gs, c.ext, c.gprwr, c.bsel, c.dmwr,
            c.jsome, c.npc, c.jr, c.jal, c.sb, c.lb, c.ill};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {state, PCWr, IRWr, ALU_OP, WDSel, GPRSel, ExtOp, GPRWr, BSel, DMWr,
            jsome, npc_sel, jr, jal, sb, lb, ill};
  endfunction

  function automatic cyc_t blank(logic [2:0] st);
    cyc_t c;
    c = '{default: '0};
    c.st  = st;
    c.ill = ill_m;
    c.z   = 1'($urandom);
    c.imr = 1'($urandom);
    c.dmr = 1'($urandom);
    return c;
  endfunction

  function automatic logic [31:0] mk(int k);
    logic [31:0] r;
    logic [5:0]  op, fn;
    r = $urandom;
    case (k)
      K_ADDU:  begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
      K_SUBU:  begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
      K_SLT:   begin r[31:26] = 6'h00; r[5:0] = 6'h2a; end
      K_JR:    begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      K_ORI:   r[31:26] = 6'h0d;
      K_ADDI:  r[31:26] = 6'h08;
      K_ADDIU: r[31:26] = 6'h09;
      K_LUI:   r[31:26] = 6'h0f;
      K_LW:    r[31:26] = 6'h23;
      K_SW:    r[31:26] = 6'h2b;
      K_LB:    r[31:26] = 6'h20;
      K_SB:    r[31:26] = 6'h28;
      K_BEQ:   r[31:26] = 6'h04;
      K_J:     r[31:26] = 6'h02;
      K_JAL:   r[31:26] = 6'h03;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          fn = 6'($urandom);
          while (fn inside {6'h21, 6'h23, 6'h2a, 6'h08}) fn = 6'($urandom);
          r[31:26] = 6'h00;
          r[5:0]   = fn;
        end else begin
          op = 6'($urandom);
          while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0d, 6'h0f,
                            6'h20, 6'h23, 6'h28, 6'h2b}) op = 6'($urandom);
          r[31:26] = op;
        end
      end
    endcase
    return r;
  endfunction

  // Expected trace of one instruction: nif fetch stalls, nmem data stalls.
  task automatic build(int k, logic zero, int nif, int nmem);
    cyc_t c;
    bit   store, load;
    plan.delete();
    for (int i = 0; i < nif; i++) begin
      c = blank(3'd0); c.imr = 1'b0; plan.push_back(c);
    end
    c = blank(3'd0); c.imr = 1'b1; c.pcwr = 1'b1; c.irwr = 1'b1; plan.push_back(c);
    c = blank(3'd1);
    case (k)
      K_J:   begin c.pcwr = 1; c.jsome = 1; end
      K_JAL: begin c.pcwr = 1; c.jsome = 1; c.jal = 1; c.gprwr = 1; c.gs = 2; c.wd = 2; end
      K_JR:  begin c.pcwr = 1; c.jr = 1; c.alu = 3; end
      default: ;
    endcase
    plan.push_back(c);
    if (k == K_ILL) ill_m = 1'b1;
    if (k inside {K_J, K_JAL, K_JR, K_ILL}) return;
    c = blank(3'd2);
    case (k)
      K_ADDU:  c.alu = 3'b000;
      K_SUBU:  c.alu = 3'b001;
      K_SLT:   c.alu = 3'b101;
      K_ORI:   begin c.bsel = 1; c.alu = 3'b011; c.ext = 2'b00; end
      K_ADDI:  begin c.bsel = 1; c.alu = 3'b110; c.ext = 2'b01; end
      K_ADDIU: begin c.bsel = 1; c.alu = 3'b000; c.ext = 2'b01; end
      K_LUI:   begin c.bsel = 1; c.alu = 3'b011; c.ext = 2'b10; end
      K_BEQ:   begin c.alu = 3'b001; c.npc = 1; c.z = zero; c.pcwr = zero; end
      default: begin c.bsel = 1; c.alu = 3'b000; c.ext = 2'b01; end
    endcase
    plan.push_back(c);
    if (k == K_BEQ) return;
    store = k inside {K_SW, K_SB};
    load  = k inside {K_LW, K_LB};
    if (store || load) begin
      for (int i = 0; i <= nmem; i++) begin
        c = blank(3'd3);
        c.alu = 3'b000; c.ext = 2'b01; c.bsel = 1;
        c.dmwr = store; c.sb = (k == K_SB); c.lb = (k == K_LB);
        c.dmr = (i == nmem);
        plan.push_back(c);
      end
      if (store) return;
    end
    c = blank(3'd4);
    c.gprwr = 1;
    c.wd = load ? 2'b01 : 2'b00;
    c.gs = (k <= K_SLT) ? 2'b01 : 2'b00;
    c.lb = (k == K_LB);
    plan.push_back(c);
  endtask

  // Replay up to nmax cycles of the plan, comparing every cycle.
  task automatic exec(logic [31:0] cd, int nmax);
    logic [23:0] act, exp;
    obs.delete();
    for (int i = 0; i < plan.size() && i < nmax; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; code = cd; Zero = plan[i].z; im_rdy = plan[i].imr; dm_rdy = plan[i].dmr;
      @(negedge clk);
      act = dut_vec();
      exp = pk(plan[i]);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle code=%h step=%0d got=%h want=%h", cd, i, act, exp);
      end
      obs.push_back(act);
    end
  endtask

  task automatic run(int k, logic [31:0] cd, logic zero, int nif, int nmem);
    build(k, zero, nif, nmem);
    exec(cd, 1000);
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // rst for n cycles: controls zero at once, state/ill zero once an edge saw rst.
  task automatic do_reset(int n);
    logic [23:0] act;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; Zero = 1'($urandom); im_rdy = 1'($urandom); dm_rdy = 1'($urandom);
      @(negedge clk);
      act = dut_vec();
      lit("rst_ctrl", {12'd0, act[20:1]}, 32'd0);
      if (i > 0) lit("rst_state", {28'd0, act[23:21], act[0]}, 32'd0);
    end
    ill_m = 1'b0;
  endtask

  initial begin
    int k, nif, nmem;
    do_reset(2);

    run(K_ADDU, 32'h00221821, 1'b0, 0, 0);
    lit("addu_len", obs.size(), 4);
    lit("addu_states", {obs[0][23:21], obs[1][23:21], obs[2][23:21], obs[3][23:21]}, 12'o0124);
    lit("addu_wb", {obs[3][13:12], obs[3][9], obs[2][18:16], obs[2][9]}, 7'b01_1_000_0);

    run(K_LW, 32'h8C080004, 1'b0, 0, 3);
    lit("lw_len", obs.size(), 8);
    lit("lw_states", {obs[0][23:21], obs[1][23:21], obs[2][23:21], obs[3][23:21],
                      obs[4][23:21], obs[5][23:21], obs[6][23:21], obs[7][23:21]}, 24'o01233334);
    lit("lw_wb", {obs[7][15:14], obs[7][9]}, 3'b01_1);

    run(K_BEQ, 32'h10220003, 1'b1, 0, 0);
    lit("beq_z1", {obs.size(), obs[2][23:21], obs[2][20], obs[2][5]}, {32'd3, 3'd2, 1'b1, 1'b1});
    run(K_BEQ, 32'h10220003, 1'b0, 0, 0);
    lit("beq_z0", {obs.size(), obs[2][20], obs[2][5]}, {32'd3, 1'b0, 1'b1});

    run(K_JAL, 32'h0C000010, 1'b0, 0, 0);
    lit("jal_id", {8'd0, obs[1]}, {8'd0, 24'b001_1_0_000_10_10_00_1_0_0_1_0_0_1_0_0_0});

    run(K_ILL, 32'hFC000000, 1'b0, 0, 0);
    lit("ill_quiet", {12'd0, obs[1][20:1]}, 32'd0);
    run(K_ADDU, 32'h00221821, 1'b0, 1, 0);
    lit("ill_sticky", {obs[0][0], obs[4][0]}, 2'b11);

    // reset while sw stalls in MEM
    build(K_SW, 1'b0, 0, 5);
    exec(32'hAC080004, 4);
    lit("sw_mem_dmwr", {obs[3][23:21], obs[3][7]}, {3'd3, 1'b1});
    do_reset(1);
    run(K_ADDU, 32'h00221821, 1'b0, 0, 0);
    lit("post_rst", {obs[0][23:21], obs[0][0]}, 4'd0);

    for (int n = 0; n < 500; n++) begin
      k    = $urandom_range(0, 15);
      nif  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      nmem = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      if ($urandom_range(0, 39) == 0) begin
        build(k, 1'($urandom), nif, nmem);
        exec(mk(k), $urandom_range(1, 6));
        do_reset($urandom_range(1, 2));
      end else begin
        run(k, mk(k), 1'($urandom), nif, nmem);
      end
    end

    do_reset(2);
    run(K_SLT, mk(K_SLT), 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
